// File: rtl/uart_tx_arbiter_if.sv
// Byte-source / UART-TX handshake bundle between the arbiter and its environment.
// The master modport is the arbiter; the slave modport is the requesters plus the TX.
interface uart_tx_arbiter_if #(
  parameter int P_NUM_REQ = 4
);
  localparam int GW = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;

  logic [P_NUM_REQ-1:0]   req_valid;
  logic [8*P_NUM_REQ-1:0] req_data;
  logic [P_NUM_REQ-1:0]   req_last;
  logic [P_NUM_REQ-1:0]   req_ready;
  logic                   tx_start;
  logic [7:0]             tx_data;
  logic                   tx_busy;
  logic                   grant_valid;
  logic [GW-1:0]          grant_id;
  logic                   ack_timeout;

  modport master (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, tx_data, grant_valid, grant_id, ack_timeout
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_start, tx_data, grant_valid, grant_id, ack_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among byte sources, with burst
// limiting, a tx_start/tx_busy handshake and a timeout for a start the TX never took.
module uart_tx_arbiter #(
  parameter int P_NUM_REQ   = 4,
  parameter int P_MAX_BURST = 4,
  parameter int P_ACK_TO    = 32
) (
  input  logic              x16_BAUD,
  input  logic              reset,
  uart_tx_arbiter_if.master bus
);
  localparam int GW = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;
  localparam int BW = $clog2(P_MAX_BURST + 1);
  localparam int AW = $clog2(P_ACK_TO);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          grant_id_q, grant_id_d;
  logic [GW-1:0]          last_grant_q, last_grant_d;
  logic                   grant_valid_q, grant_valid_d;
  logic                   last_flag_q, last_flag_d;
  logic [BW-1:0]          burst_cnt_q, burst_cnt_d;
  logic [AW-1:0]          ack_cnt_q, ack_cnt_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic [P_NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                   ack_timeout_q, ack_timeout_d;

  logic [7:0]             req_byte [P_NUM_REQ];
  logic [P_NUM_REQ-1:0]   grant_onehot;
  logic [GW-1:0]          pick_id;
  logic                   pick_found;
  logic                   cur_valid;
  logic                   ack_expire;

  for (genvar gi = 0; gi < P_NUM_REQ; gi++) begin : g_req
    assign req_byte[gi]     = bus.req_data[8*gi +: 8];
    assign grant_onehot[gi] = (grant_id_q == GW'(gi));
  end

  assign cur_valid  = bus.req_valid[grant_id_q];
  assign ack_expire = (state_q == S_WAIT_ACK) && !bus.tx_busy &&
                      (ack_cnt_q == AW'(P_ACK_TO - 1));

  // First asserted requester strictly after the previous owner, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = 1; k <= P_NUM_REQ; k++) begin
      if (!pick_found && bus.req_valid[(int'(last_grant_q) + k) % P_NUM_REQ]) begin
        pick_found = 1'b1;
        pick_id    = GW'((int'(last_grant_q) + k) % P_NUM_REQ);
      end
    end
  end

  always_ff @(posedge x16_BAUD or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      grant_id_q    <= '0;
      last_grant_q  <= GW'(P_NUM_REQ - 1);
      grant_valid_q <= 1'b0;
      last_flag_q   <= 1'b0;
      burst_cnt_q   <= '0;
      ack_cnt_q     <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      req_ready_q   <= '0;
      ack_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
      grant_valid_q <= grant_valid_d;
      last_flag_q   <= last_flag_d;
      burst_cnt_q   <= burst_cnt_d;
      ack_cnt_q     <= ack_cnt_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      req_ready_q   <= req_ready_d;
      ack_timeout_q <= ack_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    grant_valid_d = grant_valid_q;
    last_flag_d   = last_flag_q;
    burst_cnt_d   = burst_cnt_q;
    ack_cnt_d     = ack_cnt_q;
    tx_data_d     = tx_data_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_id_d    = pick_id;
          grant_valid_d = 1'b1;
          burst_cnt_d   = '0;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cur_valid) begin
          tx_data_d   = req_byte[grant_id_q];
          last_flag_d = bus.req_last[grant_id_q];
          burst_cnt_d = burst_cnt_q + BW'(1);
          ack_cnt_d   = '0;
          state_d     = S_WAIT_ACK;
        end else begin
          grant_valid_d = 1'b0;
          last_grant_d  = grant_id_q;
          state_d       = S_IDLE;
        end
      end
      S_WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (ack_expire) begin
          // The lost byte counts as consumed; the grant is given up, not retried.
          grant_valid_d = 1'b0;
          last_grant_d  = grant_id_q;
          state_d       = S_IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + AW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (last_flag_q || (burst_cnt_q == BW'(P_MAX_BURST)) || !cur_valid) begin
            grant_valid_d = 1'b0;
            last_grant_d  = grant_id_q;
            state_d       = S_IDLE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pulses are registered so tx_start appears together with the byte it loads.
  always_comb begin
    tx_start_d    = 1'b0;
    req_ready_d   = '0;
    ack_timeout_d = ack_expire;
    if ((state_q == S_ISSUE) && cur_valid) begin
      tx_start_d  = 1'b1;
      req_ready_d = grant_onehot;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.ack_timeout = ack_timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued byte sources, a TX model with configurable
// ack delay / frame length, and a message-level round-robin reference model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int TO = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.P_NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.P_NUM_REQ(N), .P_MAX_BURST(MB), .P_ACK_TO(TO)) dut (
    .x16_BAUD (clk),
    .reset    (rst),
    .bus      (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] q_data [N][$];
  bit         q_last [N][$];
  bit         drop   [N];

  int ack_delay  = 0;
  int frame_len  = 3;
  bit tx_never   = 0;
  bit tx_pending = 0;
  int tx_cnt     = 0;
  int busy_left  = 0;

  int             obs_id   [$];
  logic [7:0]     obs_data [$];
  logic [N-1:0]   obs_rr   [$];
  int             obs_cyc  [$];
  int             to_cyc   [$];
  int             gnt_q    [$];
  int             viol_pair, viol_busy, viol_to_gv;
  bit             prev_gv;
  int             cyc = 0;

  int             exp_id   [$];
  logic [7:0]     exp_data [$];
  int             exp_gnt  [$];
  int             model_last = N - 1;

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (q_data[i].size() > 0 && !drop[i]) begin
        bus.req_valid[i]     = 1'b1;
        bus.req_data[8*i+:8] = q_data[i][0];
        bus.req_last[i]      = q_last[i][0];
      end else begin
        bus.req_valid[i]     = 1'b0;
        bus.req_data[8*i+:8] = 8'h00;
        bus.req_last[i]      = 1'b0;
      end
    end
  endtask

  // One clock: observe outputs at the falling edge, then react after the rising edge.
  task automatic tick();
    logic [N-1:0] rr;
    logic [N-1:0] oh;
    bit           started;
    @(negedge clk);
    cyc++;
    rr      = bus.req_ready;
    started = bus.tx_start;
    oh      = '0;
    oh[bus.grant_id] = 1'b1;
    if (started) begin
      obs_id.push_back(int'(bus.grant_id));
      obs_data.push_back(bus.tx_data);
      obs_rr.push_back(rr);
      obs_cyc.push_back(cyc);
      if (rr !== oh) viol_pair++;
      if (bus.tx_busy) viol_busy++;
    end else if (rr !== '0) begin
      viol_pair++;
    end
    if (bus.ack_timeout) begin
      to_cyc.push_back(cyc);
      if (bus.grant_valid) viol_to_gv++;
    end
    if (bus.grant_valid && !prev_gv) gnt_q.push_back(int'(bus.grant_id));
    prev_gv = bus.grant_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rr[i] && q_data[i].size() > 0) begin
        void'(q_data[i].pop_front());
        void'(q_last[i].pop_front());
      end
    end
    drive_reqs();
    if (started && !tx_never) begin
      tx_pending = 1'b1;
      tx_cnt     = ack_delay;
    end
    if (tx_pending) begin
      if (tx_cnt == 0) begin
        tx_pending  = 1'b0;
        bus.tx_busy = 1'b1;
        busy_left   = frame_len;
      end else begin
        tx_cnt--;
      end
    end else if (bus.tx_busy) begin
      busy_left--;
      if (busy_left <= 0) bus.tx_busy = 1'b0;
    end
  endtask

  task automatic clear_obs();
    obs_id.delete(); obs_data.delete(); obs_rr.delete(); obs_cyc.delete();
    to_cyc.delete(); gnt_q.delete();
    viol_pair = 0; viol_busy = 0; viol_to_gv = 0;
    prev_gv = bus.grant_valid;
  endtask

  task automatic run_until_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (bus.req_valid == '0 && !bus.grant_valid && !bus.tx_busy && !tx_pending) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) tick();
  endtask

  // Message-level reference: walk the queued messages with the round-robin rules.
  task automatic model_build(input bit one_per_grant);
    logic [7:0] d [N][$];
    bit         l [N][$];
    int         id;
    int         n;
    bit         found;
    bit         stop;
    exp_id.delete(); exp_data.delete(); exp_gnt.delete();
    for (int i = 0; i < N; i++) begin
      d[i] = q_data[i];
      l[i] = q_last[i];
    end
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      id    = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && d[(model_last + k) % N].size() > 0 && !drop[(model_last + k) % N]) begin
          found = 1'b1;
          id    = (model_last + k) % N;
        end
      end
      if (found) begin
        exp_gnt.push_back(id);
        n    = 0;
        stop = 1'b0;
        while (!stop) begin
          exp_id.push_back(id);
          exp_data.push_back(d[id][0]);
          stop = l[id][0];
          void'(d[id].pop_front());
          void'(l[id].pop_front());
          n++;
          if (n == MB || d[id].size() == 0 || one_per_grant) stop = 1'b1;
        end
        model_last = id;
      end
    end
  endtask

  task automatic test_reset();
    bus.req_valid = '1; bus.req_data = '1; bus.req_last = '0; bus.tx_busy = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (bus.grant_valid !== 1'b0) $display("FAIL reset_grant_valid: got %b expected 0", bus.grant_valid); else pass_cnt++;
    total_cnt++; if (bus.grant_id !== '0) $display("FAIL reset_grant_id: got %0d expected 0", bus.grant_id); else pass_cnt++;
    total_cnt++; if (bus.tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b expected 0", bus.tx_start); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== '0) $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); else pass_cnt++;
    total_cnt++; if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data); else pass_cnt++;
    total_cnt++; if (bus.ack_timeout !== 1'b0) $display("FAIL reset_ack_timeout: got %b expected 0", bus.ack_timeout); else pass_cnt++;
    drive_reqs();
    rst = 1'b0;
    model_last = N - 1;
    clear_obs();
    repeat (3) tick();
    total_cnt++; if (bus.grant_valid !== 1'b0) $display("FAIL reset_no_req_grant: got %b expected 0", bus.grant_valid); else pass_cnt++;
    $display("reset: outputs checked, idle with no requests");
  endtask

  task automatic test_basic();
    bit ok;
    q_data[0].push_back(8'hA5); q_last[0].push_back(1'b0);
    q_data[2].push_back(8'($urandom)); q_last[2].push_back(1'b1);
    drive_reqs(); clear_obs(); model_build(1'b0);
    run_until_idle(200, ok);
    total_cnt++; if (!ok) $display("FAIL basic_timeout: got busy expected idle within 200 cycles"); else pass_cnt++;
    total_cnt++; if (obs_id.size() != 2) $display("FAIL basic_starts: got %0d expected 2", obs_id.size()); else pass_cnt++;
    if (obs_id.size() >= 2) begin
      total_cnt++; if (obs_id[0] != 0 || obs_data[0] !== 8'hA5) $display("FAIL basic_first: got id %0d data %h expected id 0 data a5", obs_id[0], obs_data[0]); else pass_cnt++;
      total_cnt++; if (obs_rr[0] !== 4'b0001) $display("FAIL basic_ready: got %b expected 0001", obs_rr[0]); else pass_cnt++;
      total_cnt++; if (obs_id[1] != 2 || obs_data[1] !== exp_data[1]) $display("FAIL basic_second: got id %0d data %h expected id 2 data %h", obs_id[1], obs_data[1], exp_data[1]); else pass_cnt++;
    end
    total_cnt++; if (viol_pair != 0 || viol_busy != 0) $display("FAIL basic_handshake: got %0d/%0d violations expected 0/0", viol_pair, viol_busy); else pass_cnt++;
    $display("basic: %0d starts, grants %p", obs_id.size(), gnt_q);
  endtask

  task automatic test_last();
    bit ok;
    int n1;
    q_data[1].push_back(8'h11); q_last[1].push_back(1'b0);
    q_data[1].push_back(8'h22); q_last[1].push_back(1'b1);
    q_data[2].push_back(8'($urandom)); q_last[2].push_back(1'b1);
    drive_reqs(); clear_obs(); model_build(1'b0);
    run_until_idle(200, ok);
    total_cnt++; if (!ok) $display("FAIL last_timeout: got busy expected idle within 200 cycles"); else pass_cnt++;
    n1 = 0;
    foreach (obs_id[i]) if (obs_id[i] == 1) n1++;
    total_cnt++; if (n1 != 2) $display("FAIL last_req1_starts: got %0d expected 2", n1); else pass_cnt++;
    if (obs_data.size() >= 2) begin
      total_cnt++; if (obs_data[0] !== 8'h11 || obs_data[1] !== 8'h22) $display("FAIL last_bytes: got %h %h expected 11 22", obs_data[0], obs_data[1]); else pass_cnt++;
    end
    total_cnt++; if (gnt_q.size() != 2 || gnt_q[0] != 1 || gnt_q[1] != 2) $display("FAIL last_grants: got %p expected '{1, 2}", gnt_q); else pass_cnt++;
    $display("last: %0d starts for requester 1, grants %p", n1, gnt_q);
  endtask

  task automatic test_timeout();
    bit ok;
    int dly;
    tx_never = 1'b1;
    q_data[3].push_back(8'($urandom)); q_last[3].push_back(1'b0);
    q_data[0].push_back(8'($urandom)); q_last[0].push_back(1'b0);
    drive_reqs(); clear_obs(); model_build(1'b1);
    run_until_idle(300, ok);
    tx_never = 1'b0;
    total_cnt++; if (!ok) $display("FAIL timeout_hang: got busy expected idle within 300 cycles"); else pass_cnt++;
    total_cnt++; if (to_cyc.size() != 2) $display("FAIL timeout_pulses: got %0d expected 2", to_cyc.size()); else pass_cnt++;
    dly = (to_cyc.size() > 0 && obs_cyc.size() > 0) ? to_cyc[0] - obs_cyc[0] : -1;
    total_cnt++; if (dly != TO) $display("FAIL timeout_delay: got %0d expected %0d", dly, TO); else pass_cnt++;
    total_cnt++; if (viol_to_gv != 0) $display("FAIL timeout_release: got %0d grant_valid-high pulses expected 0", viol_to_gv); else pass_cnt++;
    total_cnt++; if (gnt_q.size() != 2 || gnt_q[0] != 3 || gnt_q[1] != 0) $display("FAIL timeout_grants: got %p expected '{3, 0}", gnt_q); else pass_cnt++;
    $display("timeout: delay %0d, grants %p", dly, gnt_q);
  endtask

  task automatic test_round_robin();
    bit ok;
    int want_g [5] = '{0, 1, 2, 3, 0};
    int runs [$];
    rst = 1'b1; bus.tx_busy = 1'b0; tx_pending = 1'b0;
    @(negedge clk);
    rst = 1'b0; model_last = N - 1;
    for (int i = 0; i < N; i++) begin
      for (int b = 0; b < ((i == 0) ? 8 : 4); b++) begin
        q_data[i].push_back(8'($urandom)); q_last[i].push_back(1'b0);
      end
    end
    drive_reqs(); clear_obs(); model_build(1'b0);
    run_until_idle(1000, ok);
    total_cnt++; if (!ok) $display("FAIL rr_hang: got busy expected idle within 1000 cycles"); else pass_cnt++;
    total_cnt++; if (gnt_q.size() != 5) $display("FAIL rr_grant_count: got %0d expected 5", gnt_q.size()); else pass_cnt++;
    for (int i = 0; i < 5 && i < gnt_q.size(); i++) begin
      total_cnt++; if (gnt_q[i] != want_g[i]) $display("FAIL rr_grant_%0d: got %0d expected %0d", i, gnt_q[i], want_g[i]); else pass_cnt++;
    end
    foreach (obs_id[i]) begin
      if (i == 0 || obs_id[i] != obs_id[i-1]) runs.push_back(1);
      else runs[runs.size()-1]++;
    end
    foreach (runs[i]) begin
      total_cnt++; if (runs[i] != MB) $display("FAIL rr_burst_%0d: got %0d bytes expected %0d", i, runs[i], MB); else pass_cnt++;
    end
    for (int i = 0; i < exp_id.size(); i++) begin
      total_cnt++;
      if (i >= obs_id.size()) $display("FAIL rr_byte_%0d: got nothing expected id %0d data %h", i, exp_id[i], exp_data[i]);
      else if (obs_id[i] != exp_id[i] || obs_data[i] !== exp_data[i]) $display("FAIL rr_byte_%0d: got id %0d data %h expected id %0d data %h", i, obs_id[i], obs_data[i], exp_id[i], exp_data[i]);
      else pass_cnt++;
    end
    $display("round_robin: grants %p, runs %p", gnt_q, runs);
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit found;
    frame_len = 6;
    for (int b = 0; b < 6; b++) begin
      q_data[2].push_back(8'($urandom)); q_last[2].push_back(1'b0);
    end
    drive_reqs(); clear_obs();
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      tick();
      if (bus.tx_busy && bus.grant_valid) found = 1'b1;
    end
    tick();
    total_cnt++; if (!found) $display("FAIL rmid_busy: got no frame expected tx_busy within 60 cycles"); else pass_cnt++;
    rst = 1'b1;
    #2;
    total_cnt++;
    if ({bus.grant_valid, bus.tx_start, bus.req_ready, bus.tx_data, bus.ack_timeout, bus.grant_id} !== '0)
      $display("FAIL rmid_outputs: got gv %b ts %b rr %b td %h to %b gid %0d expected all 0", bus.grant_valid, bus.tx_start, bus.req_ready, bus.tx_data, bus.ack_timeout, bus.grant_id);
    else pass_cnt++;
    bus.tx_busy = 1'b0; tx_pending = 1'b0;
    @(negedge clk);
    rst = 1'b0; model_last = N - 1;
    q_data[0].push_back(8'($urandom)); q_last[0].push_back(1'b0);
    q_data[0].push_back(8'($urandom)); q_last[0].push_back(1'b1);
    drive_reqs(); clear_obs(); model_build(1'b0);
    frame_len = 3;
    run_until_idle(500, ok);
    total_cnt++; if (!ok) $display("FAIL rmid_hang: got busy expected idle within 500 cycles"); else pass_cnt++;
    total_cnt++; if (gnt_q.size() == 0 || gnt_q[0] != 0) $display("FAIL rmid_first_pick: got %p expected first 0", gnt_q); else pass_cnt++;
    for (int i = 0; i < exp_id.size(); i++) begin
      total_cnt++;
      if (i >= obs_id.size()) $display("FAIL rmid_byte_%0d: got nothing expected id %0d data %h", i, exp_id[i], exp_data[i]);
      else if (obs_id[i] != exp_id[i] || obs_data[i] !== exp_data[i]) $display("FAIL rmid_byte_%0d: got id %0d data %h expected id %0d data %h", i, obs_id[i], obs_data[i], exp_id[i], exp_data[i]);
      else pass_cnt++;
    end
    $display("reset_mid: after reset grants %p", gnt_q);
  endtask

  task automatic test_drop();
    bit ok;
    bit found;
    frame_len = 4;
    for (int b = 0; b < 3; b++) begin
      q_data[1].push_back(8'($urandom)); q_last[1].push_back(1'b0);
    end
    drive_reqs(); clear_obs();
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      tick();
      if (bus.tx_busy) found = 1'b1;
    end
    drop[1] = 1'b1;
    drive_reqs();
    run_until_idle(200, ok);
    total_cnt++; if (!found || !ok) $display("FAIL drop_hang: got found %b idle %b expected 1 1", found, ok); else pass_cnt++;
    total_cnt++; if (obs_id.size() != 1) $display("FAIL drop_starts: got %0d expected 1", obs_id.size()); else pass_cnt++;
    total_cnt++; if (bus.grant_valid !== 1'b0) $display("FAIL drop_release: got %b expected 0", bus.grant_valid); else pass_cnt++;
    drop[1] = 1'b0;
    q_data[1].delete(); q_last[1].delete();
    drive_reqs();
    model_last = 1;
    frame_len = 3;
    $display("drop: %0d starts before release", obs_id.size());
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 6; it++) begin
      ack_delay = $urandom_range(0, 3);
      frame_len = $urandom_range(1, 5);
      for (int i = 0; i < N; i++) begin
        for (int b = 0; b < int'($urandom_range(0, 6)); b++) begin
          q_data[i].push_back(8'($urandom)); q_last[i].push_back($urandom_range(0, 2) == 0);
        end
      end
      drive_reqs(); clear_obs(); model_build(1'b0);
      run_until_idle(2000, ok);
      total_cnt++; if (!ok) $display("FAIL rand%0d_hang: got busy expected idle within 2000 cycles", it); else pass_cnt++;
      total_cnt++; if (obs_id.size() != exp_id.size()) $display("FAIL rand%0d_count: got %0d expected %0d", it, obs_id.size(), exp_id.size()); else pass_cnt++;
      for (int i = 0; i < exp_id.size(); i++) begin
        total_cnt++;
        if (i >= obs_id.size()) $display("FAIL rand%0d_byte_%0d: got nothing expected id %0d data %h", it, i, exp_id[i], exp_data[i]);
        else if (obs_id[i] != exp_id[i] || obs_data[i] !== exp_data[i]) $display("FAIL rand%0d_byte_%0d: got id %0d data %h expected id %0d data %h", it, i, obs_id[i], obs_data[i], exp_id[i], exp_data[i]);
        else pass_cnt++;
      end
      total_cnt++; if (viol_pair != 0 || viol_busy != 0) $display("FAIL rand%0d_handshake: got %0d/%0d violations expected 0/0", it, viol_pair, viol_busy); else pass_cnt++;
      $display("random %0d: %0d bytes, grants %p", it, obs_id.size(), gnt_q);
    end
    ack_delay = 0;
    frame_len = 3;
  endtask

  initial begin
    for (int i = 0; i < N; i++) drop[i] = 1'b0;
    test_reset();
    test_basic();
    test_last();
    test_timeout();
    test_round_robin();
    test_reset_mid();
    test_drop();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
